// File: rtl/arcade_input_cond.sv
// Input conditioning: PS/2 key flags merged with joysticks, cabinet merge, VBLK-framed coin pulses; SOCD_CLEAN_EN cleans opposing directions.
// Joystick to INPx 1 MCLK, key event 2 MCLK; no backpressure, inputs sampled every cycle.
module arcade_input_cond #(
  parameter int COIN_ON_FRAMES  = 3,
  parameter int COIN_OFF_FRAMES = 3,
  parameter int VBLK_SYNC       = 2
) (
  input  logic        MCLK,
  input  logic        RESET_N,
  input  logic [10:0] PS2_KEY,
  input  logic [15:0] JOY1,
  input  logic [15:0] JOY2,
  input  logic        VBLK,
  input  logic        CABINET,
  output logic [7:0]  INP0,
  output logic [7:0]  INP1,
  output logic [7:0]  INP2
);

  typedef struct packed {
    logic t1;
    logic t2;
    logic dn;
    logic up;
    logic lf;
    logic rt;
  } ctl_t;

  typedef enum logic [1:0] {C_IDLE, C_ACTIVE, C_GUARD} coin_st_t;

  function automatic ctl_t joy_ctl(input logic [15:0] j);
    ctl_t c;
    c.t1 = j[4];
    c.t2 = j[5];
    c.dn = j[2];
    c.up = j[3];
    c.lf = j[1];
    c.rt = j[0];
    return c;
  endfunction

  function automatic ctl_t socd(input ctl_t c);
    ctl_t r;
    r = c;
`ifdef SOCD_CLEAN_EN
    if (c.up && c.dn) begin
      r.up = 1'b0;
      r.dn = 1'b0;
    end
    if (c.lf && c.rt) begin
      r.lf = 1'b0;
      r.rt = 1'b0;
    end
`endif
    return r;
  endfunction

  // ---------------- key decode ----------------
  logic       tog_q;
  logic       key_evt;
  logic       key_pr;
  ctl_t       key_p1, key_p2;
  logic       k_f1, k_f2, k_s1, k_s2, k_c1, k_c2;

  assign key_evt = PS2_KEY[10] ^ tog_q;
  assign key_pr  = PS2_KEY[9];

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tog_q  <= 1'b0;
      key_p1 <= '0;
      key_p2 <= '0;
      k_f1   <= 1'b0;
      k_f2   <= 1'b0;
      k_s1   <= 1'b0;
      k_s2   <= 1'b0;
      k_c1   <= 1'b0;
      k_c2   <= 1'b0;
    end else begin
      tog_q <= PS2_KEY[10];
      if (key_evt) begin
        // P1 arrows match with or without the extended prefix
        case (PS2_KEY[8:0])
          9'h075, 9'h175: key_p1.up <= key_pr;
          9'h072, 9'h172: key_p1.dn <= key_pr;
          9'h06B, 9'h16B: key_p1.lf <= key_pr;
          9'h074, 9'h174: key_p1.rt <= key_pr;
          9'h029:         key_p1.t1 <= key_pr;
          9'h014:         key_p1.t2 <= key_pr;
          9'h005:         k_f1      <= key_pr;
          9'h006:         k_f2      <= key_pr;
          9'h016:         k_s1      <= key_pr;
          9'h01E:         k_s2      <= key_pr;
          9'h02E:         k_c1      <= key_pr;
          9'h036:         k_c2      <= key_pr;
          9'h02D:         key_p2.up <= key_pr;
          9'h02B:         key_p2.dn <= key_pr;
          9'h023:         key_p2.lf <= key_pr;
          9'h034:         key_p2.rt <= key_pr;
          9'h01C:         key_p2.t1 <= key_pr;
          9'h01B:         key_p2.t2 <= key_pr;
          default: ;
        endcase
      end
    end
  end

  // ---------------- merge ----------------
  ctl_t p1_m, p2_m, p1_c, p2_c;
  logic start1, start2, coin_req;

  assign p2_m     = key_p2 | joy_ctl(JOY2);
  assign p1_m     = key_p1 | joy_ctl(JOY1) | (p2_m & {6{~CABINET}});
  assign p1_c     = socd(p1_m);
  assign p2_c     = socd(p2_m);
  assign start1   = k_f1 | k_s1 | JOY1[6] | JOY2[6];
  assign start2   = k_f2 | k_s2 | JOY1[7] | JOY2[7];
  assign coin_req = k_f1 | k_f2 | k_c1 | k_c2 | JOY1[8] | JOY2[8];

  logic unused_joy;
  assign unused_joy = ^{JOY1[15:9], JOY2[15:9]};

  // ---------------- frame tick ----------------
  logic [VBLK_SYNC-1:0] vblk_sync;
  logic                 vblk_d;
  logic                 tick;

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vblk_sync <= '0;
      vblk_d    <= 1'b0;
    end else begin
      vblk_sync <= {vblk_sync[VBLK_SYNC-2:0], VBLK};
      vblk_d    <= vblk_sync[VBLK_SYNC-1];
    end
  end

  assign tick = vblk_sync[VBLK_SYNC-1] & ~vblk_d;

  // ---------------- coin FSM ----------------
  coin_st_t   state, state_n;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic       pend, pend_n;
  logic       coin_req_q;
  logic       coin_edge;
  logic       coin_bit;

  assign coin_edge = coin_req & ~coin_req_q;
  assign cnt_inc   = cnt + 4'd1;
  assign coin_bit  = (state == C_ACTIVE);

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= C_IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      coin_req_q <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      coin_req_q <= coin_req;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    case (state)
      C_IDLE: begin
        // ticks in IDLE are ignored, so an entry-edge tick never counts
        if (coin_edge || pend) begin
          state_n = C_ACTIVE;
          cnt_n   = '0;
          pend_n  = 1'b0;
        end
      end
      C_ACTIVE: begin
        if (coin_edge) pend_n = 1'b1;
        if (tick) begin
          if (cnt_inc == 4'(COIN_ON_FRAMES)) begin
            cnt_n   = '0;
            state_n = (COIN_OFF_FRAMES == 0) ? C_IDLE : C_GUARD;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      C_GUARD: begin
        if (coin_edge) pend_n = 1'b1;
        if (tick) begin
          if (cnt_inc == 4'(COIN_OFF_FRAMES)) begin
            cnt_n   = '0;
            state_n = C_IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: state_n = C_IDLE;
    endcase
  end

  // ---------------- output registers ----------------
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      INP0 <= 8'h3F;
      INP1 <= 8'h3F;
      INP2 <= 8'h07;
    end else begin
      INP0 <= ~{2'b11, p1_c};
      INP1 <= ~{2'b11, p2_c};
      INP2 <= ~{5'b11111, coin_bit, start2, start1};
    end
  end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond: expectations queued at stimulus time, popped at each sample point.
module tb_arcade_input_cond;

  logic        MCLK = 1'b0;
  logic        RESET_N;
  logic [10:0] PS2_KEY;
  logic [15:0] JOY1, JOY2;
  logic        VBLK, CABINET;
  logic [7:0]  INP0, INP1, INP2;

  arcade_input_cond dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .PS2_KEY(PS2_KEY), .JOY1(JOY1), .JOY2(JOY2),
    .VBLK(VBLK), .CABINET(CABINET), .INP0(INP0), .INP1(INP1), .INP2(INP2)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mism     = 0;
  logic tog      = 1'b0;
  int   lows, pulses;
  logic prev_lo;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      mism++;
      $display("FAIL scoreboard_empty: observed %0h with no expected value", obs);
      return;
    end
    e = sb.pop_front();
    compared++;
    assert (obs === e.val) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic key(input logic pr, input logic [8:0] code);
    @(negedge MCLK);
    tog     = ~tog;
    PS2_KEY = {tog, pr, code};
  endtask

  task automatic clr_count();
    lows    = 0;
    pulses  = 0;
    prev_lo = 1'b0;
  endtask

  // sample coin level before each VBLK pulse, then emit one frame
  task automatic frames(input int n);
    logic lo;
    for (int i = 0; i < n; i++) begin
      @(negedge MCLK);
      lo = ~INP2[2];
      if (lo) lows++;
      if (lo && !prev_lo) pulses++;
      prev_lo = lo;
      VBLK = 1'b1;
      repeat (4) @(negedge MCLK);
      VBLK = 1'b0;
      repeat (8) @(negedge MCLK);
    end
  endtask

  task automatic coin_pulse();
    @(negedge MCLK);
    JOY1 = 16'h0100;
    @(negedge MCLK);
    JOY1 = 16'h0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; PS2_KEY = '0; JOY1 = '0; JOY2 = '0; VBLK = 1'b0; CABINET = 1'b0;
    #23;
    push("rst_inp0", 8'h3F); push("rst_inp1", 8'h3F); push("rst_inp2", 8'h07);
    chk(INP0); chk(INP1); chk(INP2);
    @(negedge MCLK); RESET_N = 1'b1;
    repeat (3) @(negedge MCLK);
    push("idle_inp0", 8'h3F); push("idle_inp1", 8'h3F); push("idle_inp2", 8'h07);
    chk(INP0); chk(INP1); chk(INP2);

    // P1 up via extended code, two-cycle latency
    key(1'b1, 9'h175);
    push("key_up_lat1", 8'h3F); push("key_up", 8'h3B);
    @(negedge MCLK); chk(INP0);
    @(negedge MCLK); chk(INP0);
    key(1'b0, 9'h175);
    push("key_up_break", 8'h3F);
    repeat (2) @(negedge MCLK); chk(INP0);

    key(1'b1, 9'h075);
    push("key_up_noext", 8'h3B);
    repeat (2) @(negedge MCLK); chk(INP0);
    key(1'b0, 9'h075);
    push("key_up_noext_break", 8'h3F);
    repeat (2) @(negedge MCLK); chk(INP0);

    // P2 up key: ORed into P1 when upright, separate when cocktail
    key(1'b1, 9'h02D);
    push("p2key_upright_inp0", 8'h3B); push("p2key_upright_inp1", 8'h3B);
    repeat (2) @(negedge MCLK); chk(INP0); chk(INP1);
    CABINET = 1'b1;
    push("p2key_cocktail_inp0", 8'h3F); push("p2key_cocktail_inp1", 8'h3B);
    @(negedge MCLK); chk(INP0); chk(INP1);
    key(1'b0, 9'h02D);
    CABINET = 1'b0;
    repeat (2) @(negedge MCLK);

    key(1'b1, 9'h0AA);
    push("ignored_inp0", 8'h3F); push("ignored_inp1", 8'h3F); push("ignored_inp2", 8'h07);
    repeat (2) @(negedge MCLK); chk(INP0); chk(INP1); chk(INP2);

    key(1'b1, 9'h016);
    push("start1_key", 8'h06);
    repeat (2) @(negedge MCLK); chk(INP2);
    key(1'b0, 9'h016);
    push("start1_break", 8'h07);
    repeat (2) @(negedge MCLK); chk(INP2);

    // joystick path, one-cycle latency
    @(negedge MCLK); JOY2 = 16'h0010;
    push("joy2_t1_inp0", 8'h1F); push("joy2_t1_inp1", 8'h1F);
    @(negedge MCLK); chk(INP0); chk(INP1);
    CABINET = 1'b1;
    push("joy2_t1_cocktail_inp0", 8'h3F); push("joy2_t1_cocktail_inp1", 8'h1F);
    @(negedge MCLK); chk(INP0); chk(INP1);
    JOY2 = '0; CABINET = 1'b0;

    JOY1 = 16'h0003;
`ifdef SOCD_CLEAN_EN
    push("socd_lr", 8'h3F);
`else
    push("socd_lr", 8'h3C);
`endif
    @(negedge MCLK); chk(INP0);
    JOY1 = 16'h000D;
`ifdef SOCD_CLEAN_EN
    push("socd_ud", 8'h3E);
`else
    push("socd_ud", 8'h32);
`endif
    @(negedge MCLK); chk(INP0);
    JOY1 = '0;
    @(negedge MCLK);

    // held coin: exactly one 3-frame pulse
    JOY1 = 16'h0100;
    repeat (3) @(negedge MCLK);
    push("coin_held_active", 8'h03); chk(INP2);
    clr_count();
    frames(10);
    push("coin_held_lows", 3); push("coin_held_pulses", 1); push("coin_held_end", 8'h07);
    chk(lows); chk(pulses); chk(INP2);
    JOY1 = '0;
    repeat (3) @(negedge MCLK);

    // pending coin: second edge queued, third dropped
    clr_count();
    coin_pulse();
    repeat (2) @(negedge MCLK);
    frames(1);
    coin_pulse();
    coin_pulse();
    frames(12);
    push("pend_lows", 6); push("pend_pulses", 2); push("pend_end", 8'h07);
    chk(lows); chk(pulses); chk(INP2);

    // reset mid-pulse: coin drops at once, queued coin is lost
    coin_pulse();
    repeat (2) @(negedge MCLK);
    push("mid_active", 8'h03); chk(INP2);
    coin_pulse();
    @(negedge MCLK);
    RESET_N = 1'b0;
    #1;
    push("mid_reset_async", 8'h07); chk(INP2);
    @(negedge MCLK); RESET_N = 1'b1;
    clr_count();
    frames(6);
    push("mid_reset_lows", 0); chk(lows);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
- Input conditioning stage between hps_io (PS/2 key events, joysticks) and the game core's active-low INP0/INP1/INP2 ports.
- Decodes keyboard make/break events into held key flags and merges them with both joystick words.
- Applies cabinet-mode player merging.
- Shapes coin presses into frame-timed pulses (counted on VBLK) so the game CPU always samples a coin of legal width.

Parameters:
- COIN_ON_FRAMES, 3, frames the coin bit is held active per accepted coin (1..15).
- COIN_OFF_FRAMES, 3, guard frames forced inactive after each pulse before the next coin (0..15).
- VBLK_SYNC, 2, synchronizer stages on VBLK (≥2).

Ports:
- MCLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- PS2_KEY  in  11  [10] event toggle, [9] pressed, [8:0] extended+scancode.
- JOY1  in  16  player 1 joystick: [0]R [1]L [2]D [3]U [4]Trig1 [5]Trig2 [6]Start1 [7]Start2 [8]Coin.
- JOY2  in  16  player 2 joystick, same layout.
- VBLK  in  1  vertical blank from the video timing generator. Asynchronous to MCLK is allowed.
- CABINET  in  1  1 = cocktail (players separate); 0 = upright (P2 controls ORed into P1).
- INP0  out  8  active-low ~{2'b11, trig1, trig2, down, up, left, right} for P1.
- INP1  out  8  same layout for P2.
- INP2  out  8  active-low ~{5'b11111, coin, start2, start1}.

Behaviour:
- Reset (async assert, sync release):
  - all key flags 0, coin FSM IDLE, counters 0, pending 0.
  - INP0 = INP1 = 8'h3F; INP2 = 8'h07.
- Key decode:
  - An event is accepted when PS2_KEY[10] differs from its registered previous value; the flag takes PS2_KEY[9]. The previous-toggle register resets to 0.
  - Codes: X75 up, X72 down, X6B left, X74 right (extended bit ignored); 029 trig1, 014 trig2, 005 F1, 006 F2, 016 start1, 01E start2, 02E coin1, 036 coin2, 02D P2 up, 02B P2 down, 023 P2 left, 034 P2 right, 01C P2 trig1, 01B P2 trig2.
  - Other codes are ignored.
- Merge:
  - P2 = key | JOY2.
  - P1 = key | JOY1, plus P2 when CABINET = 0.
  - start1 = F1 | 016 | JOY1[6] | JOY2[6]; start2 = F2 | 01E | JOY1[7] | JOY2[7].
  - coin_req = F1 | F2 | 02E | 036 | JOY1[8] | JOY2[8].
- Latency:
  - Joystick to INPx: 1 MCLK (output register).
  - Key event to INPx: 2 MCLK.
- Frame tick: single-cycle pulse on the rising edge of the synchronized VBLK.
- Coin FSM:
  - IDLE: on a coin_req rising edge (or pending = 1), go to ACTIVE, cnt = 0, clear pending. Coin bit is asserted from the cycle after entry.
  - ACTIVE: coin bit asserted. Each tick increments cnt. When cnt reaches COIN_ON_FRAMES, go to GUARD with cnt = 0. If COIN_OFF_FRAMES = 0, go to IDLE instead.
  - GUARD: coin bit deasserted. Each tick increments cnt; at COIN_OFF_FRAMES go to IDLE.
  - A coin_req rising edge in ACTIVE/GUARD sets pending (one deep). Further edges are dropped.
  - A held coin_req produces exactly one pulse.
  - A tick coinciding with the entry edge does not count toward that pulse.
- VBLK stuck: the FSM holds its state indefinitely. There is no timeout.
- Reset mid-pulse: coin deasserts immediately (async) and pending is lost.

Optional Feature:
- Macro: SOCD_CLEAN_EN.
- Defined: per player, after merging, up&down both 1 → both 0, and left&right both 1 → both 0. Applied before output inversion. Latency is unchanged.
- Undefined: opposite directions are passed through unmodified.

Test Plan:
- Reset: hold RESET_N=0 → INP0=8'h3F, INP1=8'h3F, INP2=8'h07. Release with no input → values unchanged.
- Key event: PS2_KEY toggles with pressed=1, code 0x175 → INP0=8'h3B two cycles later. Break event → INP0=8'h3F.
- Cabinet merge: JOY2[4]=1 with CABINET=0 → INP0=8'h1F and INP1=8'h1F. With CABINET=1 → INP0=8'h3F.
- Coin pulse: JOY1[8] held for 10 frames, defaults → INP2[2]=0 for exactly 3 VBLK ticks, then 1. No second pulse.
- Pending coin: two coin edges 1 frame apart → pulse (3 ticks), guard (3 ticks high), then a second 3-tick pulse. A third edge during ACTIVE is dropped.
- SOCD: JOY1[0]=JOY1[1]=1. With SOCD_CLEAN_EN → INP0=8'h3F. Without → INP0=8'h3C.
